// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file for the single-cycle CPU.
// Two combinational operand read ports, one debug read port, one write port
// fed by the write-back mux, and a saturating count of effective writes.
// Register 0 is hardwired to zero on every read port and never written.
// Optional feature macro: REG_FILE_BYPASS_EN -- forwards same-cycle write data
// onto the two operand ports (never onto the debug port).
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              eff_wr;
  logic [DATA_W-1:0] st1, st2;

  // A write only takes effect outside reset and away from the zero register.
  assign eff_wr = reg_write && !rst && (rd_addr != '0);

  // Storage: reset clears everything and discards any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (eff_wr) begin
      regs[rd_addr] <= wr_data;
    end
  end

  // Effective-write counter, holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (eff_wr && (wr_count != {CNT_W{1'b1}})) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

  // Stored-contents reads; address 0 forced to zero on every port.
  assign st1      = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign st2      = (rs2_addr == '0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

`ifdef REG_FILE_BYPASS_EN
  // Operand ports see the value being written this cycle; eff_wr already
  // excludes reset and the zero register.
  assign rd_data1 = (eff_wr && (rd_addr == rs1_addr)) ? wr_data : st1;
  assign rd_data2 = (eff_wr && (rd_addr == rs2_addr)) ? wr_data : st2;
`else
  assign rd_data1 = st1;
  assign rd_data2 = st2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized + directed check of reg_file against an array model.
// A second instance with CNT_W=4 shares all inputs to exercise counter saturation.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, reg_write;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data1, rd_data2, dbg_data;
  logic [31:0] s_rd1, s_rd2, s_dbg;
  logic [15:0] wr_count;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m [32];
  int          cnt;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .wr_data(wr_data), .reg_write(reg_write),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .wr_count(wr_count)
  );

  reg_file #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .wr_data(wr_data), .reg_write(reg_write),
    .rd_data1(s_rd1), .rd_data2(s_rd2), .dbg_addr(dbg_addr),
    .dbg_data(s_dbg), .wr_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp_port);
    if (a == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (byp_port && !rst && reg_write && rd_addr == a) return wr_data;
`endif
    return m[a];
  endfunction

  task automatic check_outputs();
    chk("rd1", rd_data1, exp_rd(rs1_addr, 1'b1));
    chk("rd2", rd_data2, exp_rd(rs2_addr, 1'b1));
    chk("dbg", dbg_data, exp_rd(dbg_addr, 1'b0));
    chk("cnt", {16'h0, wr_count}, 32'(cnt > 65535 ? 65535 : cnt));
    chk("cnt_s", {28'h0, s_count}, 32'(cnt > 15 ? 15 : cnt));
  endtask

  // Drive one cycle from the negedge, check before the edge, advance the model.
  task automatic cyc(input bit do_chk, input logic r, input logic we,
                     input logic [4:0] rd, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    rst = r; reg_write = we; rd_addr = rd; wr_data = wd;
    rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
    #1;
    if (do_chk) check_outputs();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      cnt = 0;
    end else if (we && rd != 0) begin
      m[rd] = wd;
      cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; rd_addr = '0; wr_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    cnt = 0;
    @(negedge clk);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // reset discards a pending write and clears loaded registers
    for (int i = 1; i < 32; i++)
      cyc(1'b1, 1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i - 1), 5'(i), 5'(i));
    cyc(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd1, 5'd31);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i); #1;
      chk("rst_rd1", rd_data1, 32'h0);
      chk("rst_rd2", rd_data2, 32'h0);
      chk("rst_dbg", dbg_data, 32'h0);
    end
    chk("rst_cnt", {16'h0, wr_count}, 32'h0);

    // basic write/read
    cyc(1'b1, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    reg_write = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd31; dbg_addr = 5'd3; #1;
    chk("bas_rd1", rd_data1, 32'h1234_5678);
    chk("bas_rd2", rd_data2, 32'hFFFF_FFFF);
    chk("bas_dbg", dbg_data, 32'h1234_5678);
    chk("bas_cnt", {16'h0, wr_count}, 32'd2);

    // zero register write is ignored and uncounted
    cyc(1'b1, 1'b0, 1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0, 5'd0);
    reg_write = 1'b0; #1;
    chk("z_rd1", rd_data1, 32'h0);
    chk("z_rd2", rd_data2, 32'h0);
    chk("z_dbg", dbg_data, 32'h0);
    chk("z_cnt", {16'h0, wr_count}, 32'd2);

    // same-cycle hazard on reg 7
    cyc(1'b1, 1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd0);
    rst = 1'b0; reg_write = 1'b1; rd_addr = 5'd7; wr_data = 32'h2;
    rs1_addr = 5'd7; rs2_addr = 5'd0; dbg_addr = 5'd7; #1;
`ifdef REG_FILE_BYPASS_EN
    chk("haz_pre", rd_data1, 32'h2);
`else
    chk("haz_pre", rd_data1, 32'h1);
`endif
    chk("haz_dbg", dbg_data, 32'h1);
    cyc(1'b1, 1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd0, 5'd7);
    reg_write = 1'b0; #1;
    chk("haz_post", rd_data1, 32'h2);

    // 20 effective writes: small counter pins at 4'hF
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b0, 1'b1, 5'(1 + i % 31), $urandom, 5'(i), 5'(1 + i % 31), 5'd3);
    reg_write = 1'b0; #1;
    chk("sat_s", {28'h0, s_count}, 32'hF);
    chk("sat_cnt", {16'h0, wr_count}, 32'(cnt));

    // reset mid-stream while alternating writes to regs 1 and 2
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b0, 1'b1, 5'(1 + i % 2), $urandom | 32'h1, 5'd1, 5'd2, 5'd1);
    cyc(1'b1, 1'b1, 1'b1, 5'd1, 32'h5555_5555, 5'd1, 5'd2, 5'd2);
    reg_write = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2; dbg_addr = 5'd2; #1;
    chk("mid_rd1", rd_data1, 32'h0);
    chk("mid_rd2", rd_data2, 32'h0);
    chk("mid_dbg", dbg_data, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 5'd2, 32'h77, 5'd1, 5'd2, 5'd2);
    reg_write = 1'b0; #1;
    chk("mid_cnt", {16'h0, wr_count}, 32'd1);
    chk("mid_val", rd_data2, 32'h77);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r, we;
      logic [4:0] rd;
      r  = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc(1'b1, r, we, rd, $urandom, 5'($urandom), 5'($urandom),
          ($urandom_range(0, 3) == 0) ? rd : 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
